sub_shift_iter: RTL and testbench

- Iterative SubBytes + ShiftRows stage of the AES encryption round, directly upstream of mix_columns.
- Accepts one 128-bit state over a valid/ready handshake and substitutes one 32-bit column per cycle through four instances of the team's existing combinational sbox module (8-bit in, 8-bit out).
- Presents the ShiftRows-permuted result on a held valid/ready output that drives the mix_columns input directly.

---
 rtl/sub_shift_iter_if.sv | 20 ++
 rtl/sub_shift_iter.sv | 121 ++++++++++++
 tb/tb_sub_shift_iter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_shift_iter_if.sv
// Handshake bundle for sub_shift_iter: upstream state in, ShiftRows(SubBytes) out.
// slave = the block itself, master = whoever drives in_* and consumes out_*.
interface sub_shift_iter_if;
   logic         in_valid;
   logic         in_ready;
   logic [0:127] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [0:127] out_data;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/sub_shift_iter.sv
// Iterative AES SubBytes + ShiftRows, one 32-bit column per cycle through four S-boxes.
// Optional SUB_SHIFT_BLKCNT_EN adds a 16-bit wrapping count of completed output transfers.
module sub_shift_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign y = SBOX[a];
endmodule

module sub_shift_iter (
   input  logic clk,
   input  logic rst,
   sub_shift_iter_if.slave bus
`ifdef SUB_SHIFT_BLKCNT_EN
   ,
   output logic [15:0] blk_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

   state_t       state, state_nx;
   logic [1:0]   col;
   logic [0:127] st_buf;
   logic [6:0]   col_base;
   logic [0:31]  cur_col, new_col;
   logic [3:0][7:0] sb_in, sb_out;
   logic [0:127] shifted;
   logic         in_ready, out_valid;

   assign col_base = {col, 5'b0};
   assign cur_col  = st_buf[col_base +: 32];

   // lane l handles byte 4*col+l of the active column
   for (genvar l = 0; l < 4; l++) begin : g_lane
      assign sb_in[l] = cur_col[8*l +: 8];
      sub_shift_sbox u_sbox (.a(sb_in[l]), .y(sb_out[l]));
   end
   assign new_col = {sb_out[0], sb_out[1], sb_out[2], sb_out[3]};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_nx = SUB;
         end
         SUB: begin
            if (col == 2'd3) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col    <= 2'd0;
         st_buf <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               st_buf <= bus.in_data;
               col    <= 2'd0;
            end
            SUB: begin
               st_buf[col_base +: 32] <= new_col;
               col                    <= col + 2'd1;
            end
            default: ;
         endcase
      end
   end

   // ShiftRows is pure wiring: row r rotates left by r columns
   always_comb begin
      shifted = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            shifted[8*(r+4*c) +: 8] = st_buf[8*(r+4*((c+r)%4)) +: 8];
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = shifted;

`ifdef SUB_SHIFT_BLKCNT_EN
   always_ff @(posedge clk) begin
      if (rst)                          blk_cnt <= 16'd0;
      else if (out_valid && bus.out_ready) blk_cnt <= blk_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_sub_shift_iter.sv
// Bench for sub_shift_iter: S-box modelled from GF(2^8) inversion + affine map.
module tb_sub_shift_iter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   sub_shift_iter_if bus();

`ifdef SUB_SHIFT_BLKCNT_EN
   logic [15:0] blk_cnt;
   logic [15:0] exp_cnt = 16'd0;
   sub_shift_iter dut (.clk(clk), .rst(rst), .bus(bus.slave), .blk_cnt(blk_cnt));
   always @(posedge clk) begin
      if (rst) exp_cnt <= 16'd0;
      else if (bus.out_valid && bus.out_ready) exp_cnt <= exp_cnt + 16'd1;
   end
`else
   sub_shift_iter dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, want finish before 800us");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rot8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox_m(input logic [7:0] a);
      logic [7:0] inv = 8'h01;
      if (a == 8'h00) inv = 8'h00;
      else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
      return inv ^ rot8(inv, 1) ^ rot8(inv, 2) ^ rot8(inv, 3) ^ rot8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [0:127] ref_ss(input logic [0:127] d);
      logic [0:127] o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(r+4*c) +: 8] = sbox_m(d[8*(r+4*((c+r)%4)) +: 8]);
      return o;
   endfunction

   function automatic logic [0:127] mixcol_m(input logic [0:127] d);
      logic [0:127] o = '0;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = d[32*c +: 8]; a1 = d[32*c+8 +: 8]; a2 = d[32*c+16 +: 8]; a3 = d[32*c+24 +: 8];
         o[32*c    +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
         o[32*c+8  +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
         o[32*c+16 +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
         o[32*c+24 +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
      return o;
   endfunction

   function automatic logic [0:127] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept d, wait for the result, hold it for 'stall' cycles, then take it.
   task automatic run_block(input logic [0:127] d, input int stall, input bit poke,
                            output logic [0:127] got, output int lat);
      int n = 0;
      bus.out_ready = 1'b0;
      while (!bus.in_ready && n < 50) begin step(); n++; end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      step();
      bus.in_valid = 1'b0;
      bus.in_data  = rnd128();
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         bus.in_valid = poke && (lat < 2);
         if (poke) bus.in_data = rnd128();
         step();
         lat++;
      end
      bus.in_valid = 1'b0;
      got = bus.out_data;
      for (int i = 0; i < stall; i++) begin
         step();
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== got || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold: valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                     bus.out_valid, bus.in_ready, bus.out_data, got);
         end
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 128'h0) begin
         bad++;
         $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h want 1 0 0",
                  bus.in_ready, bus.out_valid, bus.out_data);
      end
   endtask

   task automatic test_vec1();
      logic [0:127] got;
      int lat;
      run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, 1'b0, got, lat);
      total++;
      if (got !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin
         bad++; $display("FAIL vec1_data: got %h want d4bf5d30e0b452aeb84111f11e2798e5", got);
      end
      total++;
      if (lat !== 4) begin bad++; $display("FAIL vec1_latency: got %0d want 4", lat); end
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL vec1_one_cycle: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_vec2_mixcol();
      logic [0:127] got, want;
      int lat;
      want = 128'h49db873b453953897f02d2f177de961a;
      run_block(128'ha49c7ff2689f352b6b5bea43026a5049, 0, 1'b0, got, lat);
      total++;
      if (got !== want) begin bad++; $display("FAIL vec2_data: got %h want %h", got, want); end
      total++;
      if (mixcol_m(got) !== mixcol_m(ref_ss(128'ha49c7ff2689f352b6b5bea43026a5049))) begin
         bad++; $display("FAIL vec2_mixcol: got %h want %h", mixcol_m(got), mixcol_m(want));
      end
   endtask

   task automatic test_stall();
      logic [0:127] got;
      int lat;
      run_block(128'h0, 10, 1'b0, got, lat);
      total++;
      if (got !== {16{8'h63}}) begin bad++; $display("FAIL stall_data: got %h want all 63", got); end
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL stall_release: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_ignore_in_sub();
      logic [0:127] got;
      int lat;
      run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, 1'b1, got, lat);
      total++;
      if (got !== 128'hd4bf5d30e0b452aeb84111f11e2798e5 || lat !== 4) begin
         bad++; $display("FAIL ignore_in_sub: got %h lat %0d want d4bf5d30e0b452aeb84111f11e2798e5 lat 4", got, lat);
      end
      step();
      total++;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ignore_no_extra: in_ready=%b want 1", bus.in_ready); end
   endtask

   task automatic test_rst_mid();
      logic [0:127] got;
      int lat;
      bus.in_valid = 1'b1;
      bus.in_data  = rnd128();
      step();
      bus.in_valid = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 128'h0) begin
         bad++; $display("FAIL rst_mid: in_ready=%b out_valid=%b out_data=%h want 1 0 0",
                         bus.in_ready, bus.out_valid, bus.out_data);
      end
      run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, 1'b0, got, lat);
      total++;
      if (got !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin
         bad++; $display("FAIL rst_mid_fresh: got %h want d4bf5d30e0b452aeb84111f11e2798e5", got);
      end
   endtask

   task automatic test_random();
      logic [0:127] d, got;
      int lat;
      for (int i = 0; i < 16; i++) begin
         d = rnd128();
         run_block(d, $urandom_range(0, 3), 1'b0, got, lat);
         total++;
         if (got !== ref_ss(d) || lat !== 4) begin
            bad++; $display("FAIL random_%0d: got %h lat %0d want %h lat 4", i, got, lat, ref_ss(d));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [0:127] exp_q[$];
      int acc_cyc[$];
      logic [0:127] w;
      bit acc;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = rnd128();
      for (int cyc = 0; cyc < 40; cyc++) begin
         acc = bus.in_ready && bus.in_valid;
         if (acc) begin exp_q.push_back(ref_ss(bus.in_data)); acc_cyc.push_back(cyc); end
         if (bus.out_valid) begin
            w = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
            total++;
            if (bus.out_data !== w) begin bad++; $display("FAIL b2b_data: got %h want %h", bus.out_data, w); end
         end
         step();
         if (acc) bus.in_data = rnd128();
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
         if (bus.out_valid) begin
            w = exp_q.pop_front();
            total++;
            if (bus.out_data !== w) begin bad++; $display("FAIL b2b_drain: got %h want %h", bus.out_data, w); end
         end
         step();
      end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_timeout: %0d results missing want 0", exp_q.size()); end
      for (int i = 1; i < acc_cyc.size(); i++) begin
         total++;
         if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
            bad++; $display("FAIL b2b_interval: got %0d want 6", acc_cyc[i] - acc_cyc[i-1]);
         end
      end
      total++;
      if (acc_cyc.size() < 6) begin bad++; $display("FAIL b2b_count: got %0d accepts want >=6", acc_cyc.size()); end
      bus.out_ready = 1'b0;
      step();
   endtask

`ifdef SUB_SHIFT_BLKCNT_EN
   task automatic test_blkcnt();
      logic [0:127] got;
      logic [15:0]  base;
      int lat;
      total++;
      if (blk_cnt !== exp_cnt) begin bad++; $display("FAIL blkcnt_running: got %0d want %0d", blk_cnt, exp_cnt); end
      base = blk_cnt;
      for (int i = 0; i < 3; i++) run_block(rnd128(), 0, 1'b0, got, lat);
      total++;
      if (blk_cnt !== base + 16'd3) begin bad++; $display("FAIL blkcnt_three: got %0d want %0d", blk_cnt, base + 16'd3); end
      force dut.blk_cnt = 16'hFFFF;
      #1;
      release dut.blk_cnt;
      run_block(rnd128(), 2, 1'b0, got, lat);
      total++;
      if (blk_cnt !== 16'h0000) begin bad++; $display("FAIL blkcnt_wrap: got %h want 0000", blk_cnt); end
   endtask
`endif

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_vec1();
      test_vec2_mixcol();
      test_stall();
      test_ignore_in_sub();
      test_rst_mid();
      test_random();
      test_back_to_back();
`ifdef SUB_SHIFT_BLKCNT_EN
      test_blkcnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
